// File: rtl/regfile_bank.sv
// Two-read / two-write integer register file with an optional write-to-read bypass,
// a pending-write scoreboard, and a clear engine that zeroes the array after reset.
module regfile_bank #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   rd0,
  input  logic [AW-1:0]   rd1,
  input  logic [XLEN-1:0] wdata0,
  input  logic [XLEN-1:0] wdata1,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            ready
);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] regs_q [NREG];

  logic            ent_we [NREG];
  logic [XLEN-1:0] ent_wd [NREG];

  logic accept;
  logic wr0, wr1, iss;

  assign accept = (state_q == ST_READY);
  assign wr0    = accept && we0 && (rd0 != '0);
  assign wr1    = accept && we1 && (rd1 != '0);
  assign iss    = accept && iss_en && (iss_rd != '0);
  assign ready  = accept;

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_idx_q <= clr_idx_d;
    busy_q    <= busy_d;
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (rst) begin
      state_d   = ST_CLEAR;
      clr_idx_d = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // NREG is a power of two, so the index wraps back to 0 on leaving
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == LastIdx) state_d = ST_READY;
        end
        ST_READY: state_d = ST_READY;
        default:  state_d = ST_CLEAR;
      endcase
    end
  end

  // Issue is applied after the write-back clears: a newer pending writer wins.
  always_comb begin
    busy_d = busy_q;
    if (rst) begin
      busy_d = '0;
    end else begin
      if (wr0) busy_d[rd0]    = 1'b0;
      if (wr1) busy_d[rd1]    = 1'b0;
      if (iss) busy_d[iss_rd] = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      ent_we[i] = 1'b0;
      ent_wd[i] = '0;
      if (state_q == ST_CLEAR) begin
        ent_we[i] = (clr_idx_q == AW'(i));
      end else if (wr1 && (rd1 == AW'(i))) begin
        ent_we[i] = 1'b1;
        ent_wd[i] = wdata1;
      end else if (wr0 && (rd0 == AW'(i))) begin
        ent_we[i] = 1'b1;
        ent_wd[i] = wdata0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREG; i++) begin
      if (ent_we[i]) regs_q[i] <= ent_wd[i];
    end
  end

  always_comb begin
    rdata1 = '0;
    if (accept && (rs1 != '0)) begin
      rdata1 = regs_q[rs1];
      if (BYPASS) begin
        if (wr1 && (rd1 == rs1))      rdata1 = wdata1;
        else if (wr0 && (rd0 == rs1)) rdata1 = wdata0;
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (accept && (rs2 != '0)) begin
      rdata2 = regs_q[rs2];
      if (BYPASS) begin
        if (wr1 && (rd1 == rs2))      rdata2 = wdata1;
        else if (wr0 && (rd0 == rs2)) rdata2 = wdata0;
      end
    end
  end

  assign busy1 = accept & busy_q[rs1];
  assign busy2 = accept & busy_q[rs2];

endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: 32x32 with and without bypass plus a 64x16 instance, all
// driven from one stimulus stream and compared each cycle against a behavioural model.
module tb_regfile_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd0, rd1, iss_rd;
  logic        we0, we1, iss_en;
  logic [63:0] wdata0, wdata1;

  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic [63:0] c_rd1, c_rd2;
  logic        a_b1, a_b2, a_rdy, b_b1, b_b2, b_rdy, c_b1, c_b2, c_rdy;

  int n_chk = 0;
  int n_err = 0;

  // model state: index 0 = 32-entry configuration, index 1 = 16-entry configuration
  logic [63:0] mem    [2][32];
  bit          busy_m [2][32];
  int          clr_m  [2];
  bit          rdy_m  [2];

  always #5 clk = ~clk;

  regfile_bank #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) u_a (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rdata1(a_rd1), .rdata2(a_rd2),
    .busy1(a_b1), .busy2(a_b2), .we0(we0), .we1(we1), .rd0(rd0), .rd1(rd1),
    .wdata0(wdata0[31:0]), .wdata1(wdata1[31:0]), .iss_en(iss_en), .iss_rd(iss_rd),
    .ready(a_rdy));

  regfile_bank #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rdata1(b_rd1), .rdata2(b_rd2),
    .busy1(b_b1), .busy2(b_b2), .we0(we0), .we1(we1), .rd0(rd0), .rd1(rd1),
    .wdata0(wdata0[31:0]), .wdata1(wdata1[31:0]), .iss_en(iss_en), .iss_rd(iss_rd),
    .ready(b_rdy));

  regfile_bank #(.XLEN(64), .NREG(16), .BYPASS(1'b1)) u_c (
    .clk(clk), .rst(rst), .rs1(rs1[3:0]), .rs2(rs2[3:0]), .rdata1(c_rd1), .rdata2(c_rd2),
    .busy1(c_b1), .busy2(c_b2), .we0(we0), .we1(we1), .rd0(rd0[3:0]), .rd1(rd1[3:0]),
    .wdata0(wdata0), .wdata1(wdata1), .iss_en(iss_en), .iss_rd(iss_rd[3:0]),
    .ready(c_rdy));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nreg_of(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic logic [63:0] dmask_of(input int k);
    return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] exp_rd(input int k, input logic [4:0] rs, input bit byp);
    int n = nreg_of(k);
    int i = int'(rs) % n;
    if (!rdy_m[k] || i == 0) return '0;
    if (byp && we1 && (int'(rd1) % n) == i) return wdata1 & dmask_of(k);
    if (byp && we0 && (int'(rd0) % n) == i) return wdata0 & dmask_of(k);
    return mem[k][i];
  endfunction

  function automatic logic [63:0] exp_bz(input int k, input logic [4:0] rs);
    int i = int'(rs) % nreg_of(k);
    return (rdy_m[k] && busy_m[k][i]) ? 64'd1 : 64'd0;
  endfunction

  task automatic upd(input int k);
    int n  = nreg_of(k);
    int r0 = int'(rd0) % n;
    int r1 = int'(rd1) % n;
    int ri = int'(iss_rd) % n;
    if (rst) begin
      clr_m[k] = n;
      rdy_m[k] = 1'b0;
      for (int i = 0; i < 32; i++) busy_m[k][i] = 1'b0;
    end else if (!rdy_m[k]) begin
      clr_m[k]--;
      if (clr_m[k] == 0) begin
        rdy_m[k] = 1'b1;
        for (int i = 0; i < 32; i++) mem[k][i] = '0;
      end
    end else begin
      if (we0 && r0 != 0) begin mem[k][r0] = wdata0 & dmask_of(k); busy_m[k][r0] = 1'b0; end
      if (we1 && r1 != 0) begin mem[k][r1] = wdata1 & dmask_of(k); busy_m[k][r1] = 1'b0; end
      if (iss_en && ri != 0) busy_m[k][ri] = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("A.rdata1", 64'(a_rd1), exp_rd(0, rs1, 1'b1));
    chk("A.rdata2", 64'(a_rd2), exp_rd(0, rs2, 1'b1));
    chk("B.rdata1", 64'(b_rd1), exp_rd(0, rs1, 1'b0));
    chk("B.rdata2", 64'(b_rd2), exp_rd(0, rs2, 1'b0));
    chk("C.rdata1", c_rd1, exp_rd(1, rs1, 1'b1));
    chk("C.rdata2", c_rd2, exp_rd(1, rs2, 1'b1));
    chk("A.busy1", 64'(a_b1), exp_bz(0, rs1));
    chk("A.busy2", 64'(a_b2), exp_bz(0, rs2));
    chk("B.busy1", 64'(b_b1), exp_bz(0, rs1));
    chk("C.busy1", 64'(c_b1), exp_bz(1, rs1));
    chk("C.busy2", 64'(c_b2), exp_bz(1, rs2));
    chk("A.ready", 64'(a_rdy), 64'(rdy_m[0]));
    chk("B.ready", 64'(b_rdy), 64'(rdy_m[0]));
    chk("C.ready", 64'(c_rdy), 64'(rdy_m[1]));
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic tock();
    @(posedge clk);
    upd(0);
    upd(1);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    rd0 = '0; rd1 = '0; iss_rd = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_a = -1;
    int n_c = -1;
    rst = 1'b1; rs1 = '0; rs2 = '0;
    idle();
    tock();
    repeat (2) begin tick(); tock(); end
    rst = 1'b0;

    // restart the clear partway through
    repeat (10) begin tick(); tock(); end
    rst = 1'b1;
    tick(); tock();
    rst = 1'b0;

    // measure the clear, with traffic that must be ignored meanwhile
    for (int n = 0; n < 40; n++) begin
      we0 = (n >= 2 && n < 6); rd0 = 5'd3; wdata0 = 64'hFF;
      iss_en = (n >= 2 && n < 6); iss_rd = 5'd3;
      tick();
      if (c_rdy && n_c < 0) n_c = n;
      if (a_rdy) begin n_a = n; break; end
      tock();
    end
    idle();
    tock();
    chk("clear_len_32", 64'(n_a), 64'd32);
    chk("clear_len_16", 64'(n_c), 64'd16);

    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      tick();
      chk("clr_zero", 64'(a_rd1), 64'd0);
      if (i == 3) chk("clr_busy3", 64'(a_b1), 64'd0);
      tock();
    end

    we0 = 1'b1; rd0 = 5'd5; wdata0 = 64'hDEAD_BEEF;
    tick(); tock(); idle();
    rs1 = 5'd5;
    tick();
    chk("wr_x5_a", 64'(a_rd1), 64'hDEAD_BEEF);
    chk("wr_x5_b", 64'(b_rd1), 64'hDEAD_BEEF);
    tock();

    we0 = 1'b1; rd0 = 5'd0; wdata0 = 64'h1234; rs2 = 5'd0;
    tick(); tock(); idle();
    tick();
    chk("x0_zero", 64'(a_rd2), 64'd0);
    tock();

    we0 = 1'b1; rd0 = 5'd7; wdata0 = 64'h77;
    tick(); tock();
    rd0 = 5'd7; wdata0 = 64'h11; we1 = 1'b1; rd1 = 5'd7; wdata1 = 64'h22; rs1 = 5'd7;
    tick();
    chk("coll_bypass", 64'(a_rd1), 64'h22);
    chk("coll_nobypass", 64'(b_rd1), 64'h77);
    tock(); idle();
    tick();
    chk("coll_next_a", 64'(a_rd1), 64'h22);
    chk("coll_next_b", 64'(b_rd1), 64'h22);
    tock();

    iss_en = 1'b1; iss_rd = 5'd9; rs1 = 5'd9;
    tick();
    chk("busy_pre", 64'(a_b1), 64'd0);
    tock(); idle();
    tick();
    chk("busy_set", 64'(a_b1), 64'd1);
    tock();
    we0 = 1'b1; rd0 = 5'd9; wdata0 = 64'h99;
    tick();
    chk("busy_no_fwd", 64'(a_b1), 64'd1);
    tock(); idle();
    tick();
    chk("busy_clr", 64'(a_b1), 64'd0);
    tock();
    iss_en = 1'b1; iss_rd = 5'd9; we1 = 1'b1; rd1 = 5'd9; wdata1 = 64'h5;
    tick(); tock(); idle();
    tick();
    chk("busy_set_wins", 64'(a_b1), 64'd1);
    tock();

    we0 = 1'b1; rd0 = 5'd15; wdata0 = 64'hFFFF_FFFF_FFFF_FFFF; rs1 = 5'd15;
    tick();
    chk("c_x15_bypass", c_rd1, 64'hFFFF_FFFF_FFFF_FFFF);
    tock(); idle();
    tick();
    chk("c_x15", c_rd1, 64'hFFFF_FFFF_FFFF_FFFF);
    tock();

    for (int n = 0; n < 300; n++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      rd0 = 5'($urandom_range(0, 31));
      rd1 = ($urandom_range(0, 3) == 0) ? rd0 : 5'($urandom_range(0, 31));
      wdata0 = {$urandom, $urandom};
      wdata1 = {$urandom, $urandom};
      iss_en = 1'($urandom_range(0, 1));
      iss_rd = ($urandom_range(0, 3) == 0) ? rd1 : 5'($urandom_range(0, 31));
      rs1 = ($urandom_range(0, 2) == 0) ? rd0 : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 2) == 0) ? rd1 : 5'($urandom_range(0, 31));
      tick();
      tock();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
# regfile_bank

Parametrised integer register file with two combinational read ports and two write-back ports. It includes an optional write-to-read bypass, a per-register pending-write scoreboard, and a sequential clear engine that zeroes the array after reset. It sits between decode (read/issue) and write-back in the pipeline, and replaces the fixed 32x32 single-write register file.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, at least 2
- AW, $clog2(NREG), register index width (derived; not overridden)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns array contents only

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rs1, rs2  in  AW  read indices
- rdata1, rdata2  out  XLEN  read data (combinational)
- busy1, busy2  out  1  pending-write flag of rs1 / rs2 (combinational)
- we0, we1  in  1  write enables, lanes 0 and 1
- rd0, rd1  in  AW  write indices
- wdata0, wdata1  in  XLEN  write data
- iss_en  in  1  issue strobe: mark iss_rd pending
- iss_rd  in  AW  destination index being issued
- ready  out  1  array cleared and accepting traffic

## Operation
- Storage: NREG x XLEN array. Register 0 reads as 0 at all times; writes to it are discarded and it is never marked busy.
- FSM states:
  - CLEAR: clr_idx counts 0..NREG-1 and writes 0 to one entry per cycle; leaves to READY after the entry at NREG-1 is written.
  - READY: normal operation.
- rst asserted in any state:
  - next state is CLEAR, clr_idx <= 0, all busy bits <= 0.
  - Reset in the middle of a clear restarts the clear from index 0.
- During CLEAR:
  - we0/we1/iss_en are ignored.
  - rdata* = 0, busy* = 0, ready = 0.
- Writes (READY only):
  - Each lane with weN=1 and rdN!=0 writes wdataN to rdN at the clock edge.
  - If both lanes target the same nonzero index, lane 1 wins.
- Scoreboard (READY only):
  - The write of lane N clears busy[rdN].
  - iss_en sets busy[iss_rd] (iss_rd!=0).
  - If a set and a clear hit the same index in the same cycle, the set wins, because the newer instruction is still pending.
  - Setting an already-busy bit is legal and leaves it 1.
- Reads:
  - rdataK = x[rsK], with x0 forced to 0.
  - With BYPASS=1 and READY, a matching write in the same cycle forwards its data instead: lane 1 is checked first, then lane 0. rsK=0 is never bypassed.
  - busyK = busy[rsK]. There is no bypass on busy: a same-cycle clear is visible on the next cycle.

## Timing
- Reset values (the cycle after rst is sampled high): ready=0, state CLEAR, clr_idx=0, busy all 0, rdata*=0, busy*=0.
- The clear takes exactly NREG cycles after rst is deasserted. ready rises on the cycle after the last clear write (the (NREG+1)-th edge after rst falls is the first edge that accepts writes).
- Write latency: data is visible in the array on the cycle after the edge. With BYPASS=1 it is also visible on the read ports in the same cycle as weN.
- Issue latency: busy is visible from the cycle after iss_en.
- No back-pressure: every input is accepted unconditionally in READY.

## Test plan
- Reset and clear: hold rst 3 cycles, then release with NREG=32.
  - ready stays 0 for 32 cycles, then goes 1.
  - All 32 reads return 0.
  - Assert rst again after 10 clear cycles: ready stays 0 for a full 32 more cycles.
- Basic write/read: write x5=0xDEADBEEF on lane 0, then read rs1=5 on the next cycle.
  - Returns 0xDEADBEEF.
  - Writing x0=0x1234 leaves a read of rs2=0 at 0.
- Dual-write collision: same cycle, we0 with x7=0x11 and we1 with x7=0x22.
  - Next-cycle read of x7 = 0x22.
  - With BYPASS=1, the same-cycle read of rs1=7 = 0x22.
  - With BYPASS=0, the same-cycle read returns the old value.
- Scoreboard: iss_en with iss_rd=9, then busy1 (rs1=9) = 1.
  - A later we0 to x9 gives busy1=0 on the following cycle.
  - Simultaneous iss_en rd=9 and we1 rd=9 leaves busy1=1.
- Traffic during CLEAR: drive we0 x3=0xFF and iss_en rd=3 while ready=0.
  - After ready=1, x3=0 and busy[3]=0.
- Parameter sweep: XLEN=64, NREG=16.
  - The clear takes 16 cycles.
  - A write of x15=0xFFFF_FFFF_FFFF_FFFF reads back intact.
